elem_unpacker: RTL and testbench

- Successor to the fixed-width separator; the generalised length-driven unpacker for memory read beats.
- Accepts wide read-data beats plus a queue of per-message lengths, and emits each message as a stream of LANES x ELEM_W output words.
- Full AXI-stream handshake on all three interfaces: output backpressure, partial last word with lane keep, zero-length messages.
- Sits between the DDR read path (ui_clk domain) and the MPI operation datapath.

---
 rtl/elem_unpacker.sv | 211 +++++++++++++++++++++
 tb/tb_elem_unpacker.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/elem_unpacker.sv
// Length-driven unpacker: splits wide read beats into LANES x ELEM_W words, one message per queued length.
// Optional ELEM_UNPACKER_LSB_FIRST_EN selects LSB-first slot and lane ordering.
module elem_unpacker #(
  parameter int unsigned DATA_W    = 512,
  parameter int unsigned ELEM_W    = 16,
  parameter int unsigned LANES     = 1,
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned LEN_DEPTH = 4
) (
  input  logic                    ui_clk,
  input  logic                    aresetn,
  input  logic [LEN_W-1:0]        len_data,
  input  logic                    len_valid,
  output logic                    len_ready,
  input  logic [DATA_W-1:0]       rdata,
  input  logic                    rvalid,
  output logic                    rready,
  output logic [ELEM_W*LANES-1:0] odata,
  output logic                    ovalid,
  input  logic                    oready,
  output logic                    ostart,
  output logic                    olast,
  output logic [LANES-1:0]        okeep
);

  localparam int unsigned WORD_W = ELEM_W * LANES;
  localparam int unsigned SLOTS  = DATA_W / WORD_W;
  localparam int unsigned SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int unsigned PTR_W  = (LEN_DEPTH > 1) ? $clog2(LEN_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, FETCH, EMIT} state_e;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_mem [LEN_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                len_ready_q, len_ready_d;
  logic [DATA_W-1:0]   beat_q, beat_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [LEN_W-1:0]    rem_q, rem_d, rem_n;
  logic                first_q, first_d;
  logic [WORD_W-1:0]   odata_q, odata_d;
  logic                ovalid_q, ovalid_d, ostart_q, ostart_d, olast_q, olast_d;
  logic [LANES-1:0]    okeep_q, okeep_d;
  logic                push, pop, rready_c;

  // Extract one output word from a beat; the whole slot maps straight onto odata in either ordering.
  function automatic logic [WORD_W-1:0] slot_word(input logic [DATA_W-1:0] beat,
                                                  input logic [SLOT_W-1:0] s);
    logic [DATA_W-1:0] sh;
`ifdef ELEM_UNPACKER_LSB_FIRST_EN
    sh = beat >> (32'(s) * WORD_W);
    return sh[WORD_W-1:0];
`else
    sh = beat << (32'(s) * WORD_W);
    return sh[DATA_W-1 -: WORD_W];
`endif
  endfunction

  function automatic logic [LANES-1:0] keep_of(input logic [LEN_W-1:0] rem);
    logic [LANES-1:0] k;
    for (int i = 0; i < int'(LANES); i++) k[i] = (rem > LEN_W'(i));
    return k;
  endfunction

  function automatic logic is_last(input logic [LEN_W-1:0] rem);
    return rem <= LEN_W'(LANES);
  endfunction

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    beat_d      = beat_q;
    slot_d      = slot_q;
    rem_d       = rem_q;
    rem_n       = rem_q;
    first_d     = first_q;
    odata_d     = odata_q;
    ovalid_d    = ovalid_q;
    ostart_d    = ostart_q;
    olast_d     = olast_q;
    okeep_d     = okeep_q;
    rready_c    = 1'b0;
    pop         = 1'b0;
    push        = len_valid && len_ready_q;

    case (state_q)
      IDLE: begin
        if (cnt_q != '0) begin
          pop = 1'b1;
          // Zero-length messages only retire their queue entry.
          if (len_mem[rd_ptr_q] != '0) begin
            rem_d   = len_mem[rd_ptr_q];
            slot_d  = '0;
            first_d = 1'b1;
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        rready_c = 1'b1;
        if (rvalid) begin
          beat_d   = rdata;
          state_d  = EMIT;
          ovalid_d = 1'b1;
          odata_d  = slot_word(rdata, '0);
          okeep_d  = keep_of(rem_q);
          olast_d  = is_last(rem_q);
          ostart_d = first_q;
        end
      end
      EMIT: begin
        if (oready) begin
          rem_n    = (rem_q > LEN_W'(LANES)) ? rem_q - LEN_W'(LANES) : '0;
          rem_d    = rem_n;
          first_d  = 1'b0;
          ostart_d = 1'b0;
          if (olast_q) begin
            state_d  = IDLE;
            ovalid_d = 1'b0;
            odata_d  = '0;
            okeep_d  = '0;
            olast_d  = 1'b0;
          end else if (slot_q == SLOT_W'(SLOTS - 1)) begin
            // Beat exhausted: refill in place so the stream keeps one word per cycle.
            rready_c = 1'b1;
            if (rvalid) begin
              beat_d  = rdata;
              slot_d  = '0;
              odata_d = slot_word(rdata, '0);
              okeep_d = keep_of(rem_n);
              olast_d = is_last(rem_n);
            end else begin
              state_d  = FETCH;
              ovalid_d = 1'b0;
              odata_d  = '0;
              okeep_d  = '0;
              olast_d  = 1'b0;
            end
          end else begin
            slot_d  = SLOT_W'(slot_q + 1'b1);
            odata_d = slot_word(beat_q, SLOT_W'(slot_q + 1'b1));
            okeep_d = keep_of(rem_n);
            olast_d = is_last(rem_n);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
    if (pop)  rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
    case ({push, pop})
      2'b10:   cnt_d = CNT_W'(cnt_q + 1'b1);
      2'b01:   cnt_d = CNT_W'(cnt_q - 1'b1);
      default: cnt_d = cnt_q;
    endcase
    len_ready_d = (cnt_d != CNT_W'(LEN_DEPTH));
  end

  always_ff @(posedge ui_clk) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      len_ready_q <= 1'b0;
      beat_q      <= '0;
      slot_q      <= '0;
      rem_q       <= '0;
      first_q     <= 1'b0;
      odata_q     <= '0;
      ovalid_q    <= 1'b0;
      ostart_q    <= 1'b0;
      olast_q     <= 1'b0;
      okeep_q     <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      len_ready_q <= len_ready_d;
      beat_q      <= beat_d;
      slot_q      <= slot_d;
      rem_q       <= rem_d;
      first_q     <= first_d;
      odata_q     <= odata_d;
      ovalid_q    <= ovalid_d;
      ostart_q    <= ostart_d;
      olast_q     <= olast_d;
      okeep_q     <= okeep_d;
    end
  end

  // Queue storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge ui_clk) begin
    if (push) len_mem[wr_ptr_q] <= len_data;
  end

  assign len_ready = len_ready_q;
  assign rready    = rready_c;
  assign odata     = odata_q;
  assign ovalid    = ovalid_q;
  assign ostart    = ostart_q;
  assign olast     = olast_q;
  assign okeep     = okeep_q;

endmodule

// File: tb/tb_elem_unpacker.sv
// Directed bench for elem_unpacker: default 1-lane instance plus a 4-lane instance for partial keep.
module tb_elem_unpacker;

  logic         ui_clk;
  logic         aresetn;
  logic [15:0]  len_data;
  logic         len_valid, len_ready;
  logic [511:0] rdata;
  logic         rvalid, rready;
  logic [15:0]  odata;
  logic         ovalid, oready, ostart, olast;
  logic [0:0]   okeep;

  logic [15:0]  len_data4;
  logic         len_valid4, len_ready4;
  logic [511:0] rdata4;
  logic         rvalid4, rready4;
  logic [63:0]  odata4;
  logic         ovalid4, oready4, ostart4, olast4;
  logic [3:0]   okeep4;

  int n_assert = 0;
  int n_fail   = 0;
  int beats_taken = 0;
  logic [511:0] beat_q[$];

  elem_unpacker u_dut (
    .ui_clk(ui_clk), .aresetn(aresetn),
    .len_data(len_data), .len_valid(len_valid), .len_ready(len_ready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .odata(odata), .ovalid(ovalid), .oready(oready),
    .ostart(ostart), .olast(olast), .okeep(okeep)
  );

  elem_unpacker #(.LANES(4)) u_dut4 (
    .ui_clk(ui_clk), .aresetn(aresetn),
    .len_data(len_data4), .len_valid(len_valid4), .len_ready(len_ready4),
    .rdata(rdata4), .rvalid(rvalid4), .rready(rready4),
    .odata(odata4), .ovalid(ovalid4), .oready(oready4),
    .ostart(ostart4), .olast(olast4), .okeep(okeep4)
  );

  initial ui_clk = 1'b0;
  always #5 ui_clk = ~ui_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Read-beat source: presents the head of beat_q, retires it on an accepted handshake.
  initial begin
    logic acc;
    rvalid = 1'b0;
    rdata  = '0;
    forever begin
      @(negedge ui_clk);
      acc = rvalid && rready;
      @(posedge ui_clk);
      #1;
      if (acc) begin
        void'(beat_q.pop_front());
        beats_taken++;
      end
      rvalid = (beat_q.size() > 0);
      rdata  = rvalid ? beat_q[0] : '0;
    end
  end

  task automatic cyc();
    @(posedge ui_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] mk_beat(input logic [15:0] base);
    logic [511:0] b;
    b = '0;
    for (int n = 0; n < 32; n++) b[511-16*n -: 16] = 16'(base + 16'(n));
    return b;
  endfunction

  task automatic push_len(input logic [15:0] l);
    chk("len_ready_before_push", 64'(len_ready), 64'd1);
    len_data  = l;
    len_valid = 1'b1;
    cyc();
    len_valid = 1'b0;
  endtask

  // Wait (bounded) for a word, check it, then let it transfer with oready high.
  task automatic recv(input string tag, input logic [15:0] ed, input logic es,
                      input logic el, output int waited);
    waited = 0;
    while (!ovalid && waited < 50) begin
      cyc();
      waited++;
    end
    chk({tag, "_valid"}, 64'(ovalid), 64'd1);
    chk({tag, "_data"},  64'(odata),  64'(ed));
    chk({tag, "_start"}, 64'(ostart), 64'(es));
    chk({tag, "_last"},  64'(olast),  64'(el));
    chk({tag, "_keep"},  64'(okeep),  64'd1);
    cyc();
  endtask

  initial begin
    int w, b0, idx;
    logic [15:0] exp_d;
    logic stall_prev, start_prev, last_prev;
    logic [15:0] data_prev;

    aresetn = 1'b0; oready = 1'b1; len_valid = 1'b0; len_data = '0;
    len_valid4 = 1'b0; len_data4 = '0; rvalid4 = 1'b0; rdata4 = '0; oready4 = 1'b1;
    cyc(); cyc();
    chk("rst_ovalid", 64'(ovalid), 64'd0);
    chk("rst_rready", 64'(rready), 64'd0);
    chk("rst_len_ready", 64'(len_ready), 64'd0);
    chk("rst_odata", 64'(odata), 64'd0);
    chk("rst_okeep", 64'(okeep), 64'd0);
    aresetn = 1'b1;
    cyc();
    chk("rst_release_len_ready", 64'(len_ready), 64'd1);

    // Test 1: one full beat, and first-word latency with rvalid already up
    b0 = beats_taken;
    beat_q.push_back(mk_beat(16'h0100));
    cyc();
    push_len(16'd32);
    chk("t1_lat0", 64'(ovalid), 64'd0);
    cyc();
    chk("t1_lat1", 64'(ovalid), 64'd0);
    cyc();
    chk("t1_lat2", 64'(ovalid), 64'd1);
    for (int i = 0; i < 32; i++)
      recv($sformatf("t1w%0d", i), 16'(16'h0100 + i), i == 0, i == 31, w);
    chk("t1_idle", 64'(ovalid), 64'd0);
    chk("t1_beats", 64'(beats_taken - b0), 64'd1);

    // Test 2: message spanning two beats, tail of beat 2 discarded, then a 1-element message
    b0 = beats_taken;
    beat_q.push_back(mk_beat(16'h0200));
    beat_q.push_back(mk_beat(16'h0300));
    beat_q.push_back(mk_beat(16'h0400));
    cyc();
    push_len(16'd40);
    push_len(16'd1);
    for (int i = 0; i < 40; i++) begin
      exp_d = (i < 32) ? 16'(16'h0200 + i) : 16'(16'h0300 + i - 32);
      recv($sformatf("t2w%0d", i), exp_d, i == 0, i == 39, w);
      if (i == 32) chk("t2_no_bubble", 64'(w), 64'd0);
    end
    recv("t2m2", 16'h0400, 1'b1, 1'b1, w);
    chk("t2_beats", 64'(beats_taken - b0), 64'd3);

    // Test 4: oready 1,0,0,1 over 64 elements; stalled words must hold
    b0 = beats_taken;
    beat_q.push_back(mk_beat(16'h0500));
    beat_q.push_back(mk_beat(16'h0600));
    cyc();
    push_len(16'd64);
    idx = 0; stall_prev = 1'b0; data_prev = '0; start_prev = 1'b0; last_prev = 1'b0;
    for (int c = 0; c < 600 && idx < 64; c++) begin
      oready = ((c % 4) == 0) || ((c % 4) == 3);
      if (stall_prev) begin
        chk($sformatf("t4_hold_valid%0d", c), 64'(ovalid), 64'd1);
        chk($sformatf("t4_hold_data%0d", c), 64'(odata), 64'(data_prev));
        chk($sformatf("t4_hold_flags%0d", c), 64'({ostart, olast}), 64'({start_prev, last_prev}));
      end
      if (ovalid && oready) begin
        exp_d = (idx < 32) ? 16'(16'h0500 + idx) : 16'(16'h0600 + idx - 32);
        chk($sformatf("t4w%0d_data", idx), 64'(odata), 64'(exp_d));
        chk($sformatf("t4w%0d_flags", idx), 64'({ostart, olast}), 64'({idx == 0, idx == 63}));
        idx++;
      end
      stall_prev = ovalid && !oready;
      data_prev = odata; start_prev = ostart; last_prev = olast;
      cyc();
    end
    oready = 1'b1;
    chk("t4_count", 64'(idx), 64'd64);
    chk("t4_beats", 64'(beats_taken - b0), 64'd2);
    cyc();
    chk("t4_idle", 64'(ovalid), 64'd0);

    // Test 5: zero-length message takes no beat and emits nothing
    b0 = beats_taken;
    beat_q.push_back(mk_beat(16'h0700));
    cyc();
    push_len(16'd0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t5_zero_ovalid%0d", i), 64'(ovalid), 64'd0);
      chk($sformatf("t5_zero_rready%0d", i), 64'(rready), 64'd0);
      cyc();
    end
    chk("t5_zero_beats", 64'(beats_taken - b0), 64'd0);
    push_len(16'd2);
    recv("t5w0", 16'h0700, 1'b1, 1'b0, w);
    recv("t5w1", 16'h0701, 1'b0, 1'b1, w);
    chk("t5_beats", 64'(beats_taken - b0), 64'd1);

    // Test 6: reset mid-message, then a fresh message
    b0 = beats_taken;
    beat_q.push_back(mk_beat(16'h0800));
    beat_q.push_back(mk_beat(16'h0900));
    cyc();
    push_len(16'd32);
    for (int i = 0; i < 10; i++)
      recv($sformatf("t6w%0d", i), 16'(16'h0800 + i), i == 0, 1'b0, w);
    chk("t6_w10_data", 64'(odata), 64'h080A);
    aresetn = 1'b0;
    cyc();
    chk("t6_rst_ovalid", 64'(ovalid), 64'd0);
    chk("t6_rst_odata", 64'(odata), 64'd0);
    chk("t6_rst_okeep", 64'(okeep), 64'd0);
    chk("t6_rst_flags", 64'({ostart, olast}), 64'd0);
    chk("t6_rst_rready", 64'(rready), 64'd0);
    chk("t6_rst_len_ready", 64'(len_ready), 64'd0);
    aresetn = 1'b1;
    chk("t6_rst_len_ready_hold", 64'(len_ready), 64'd0);
    cyc();
    chk("t6_release_len_ready", 64'(len_ready), 64'd1);
    chk("t6_release_ovalid", 64'(ovalid), 64'd0);
    push_len(16'd3);
    recv("t6n0", 16'h0900, 1'b1, 1'b0, w);
    recv("t6n1", 16'h0901, 1'b0, 1'b0, w);
    recv("t6n2", 16'h0902, 1'b0, 1'b1, w);
    chk("t6_beats", 64'(beats_taken - b0), 64'd2);

    // Test 3: LANES=4, L=10 -> 3 words, partial keep on the last
    rdata4  = mk_beat(16'h0A00);
    rvalid4 = 1'b1;
    len_data4  = 16'd10;
    len_valid4 = 1'b1;
    cyc();
    len_valid4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w = 0;
      while (!ovalid4 && w < 50) begin
        cyc();
        w++;
      end
      rvalid4 = 1'b0;
      chk($sformatf("t3w%0d_valid", i), 64'(ovalid4), 64'd1);
      chk($sformatf("t3w%0d_lanes01", i), 64'(odata4[63:32]),
          64'({16'(16'h0A00 + 4*i), 16'(16'h0A00 + 4*i + 1)}));
      chk($sformatf("t3w%0d_keep", i), 64'(okeep4), (i < 2) ? 64'hF : 64'h3);
      chk($sformatf("t3w%0d_flags", i), 64'({ostart4, olast4}), 64'({i == 0, i == 2}));
      cyc();
    end
    chk("t3_idle", 64'(ovalid4), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
